calc_engine: RTL and testbench

Calculator front-end/compute block: divides the 50 MHz board clock into the key-scan and display-refresh rates, turns the 16 active-low push buttons into one-shot extended-BCD key codes plus a keypad reset request, and evaluates signed 32-bit `operand1 <op> operand2` on request with error detection. It sits between the board pins (clock, keypad) and the interface/segment logic, which consume `eBCD`, `key_rst` and `ans`.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/calc_alu.sv | 47 ++++
 rtl/calc_engine.sv | 79 +++++++
 tb/tb_calc_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator front-end: key codes, operator codes,
// error code and display range.
package calc_pkg;

  localparam logic [31:0] ERR_CODE = 32'h00EE_0000;
  localparam longint DISP_MAX = 64'sd999999;
  localparam longint DISP_MIN = -64'sd99999;

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpMul  = 3'd1,
    OpDiv  = 3'd2,
    OpAdd  = 3'd3,
    OpSub  = 3'd4,
    OpMod  = 3'd5
  } op_e;

  localparam logic [4:0] KEY_NONE   = 5'h00;
  localparam logic [4:0] KEY_DIGIT0 = 5'h10;
  localparam logic [4:0] KEY_MUL    = 5'h1A;
  localparam logic [4:0] KEY_DIV    = 5'h1B;
  localparam logic [4:0] KEY_ADD    = 5'h1C;
  localparam logic [4:0] KEY_SUB    = 5'h1D;
  localparam logic [4:0] KEY_ANS    = 5'h1E;
  localparam logic [4:0] KEY_EQ     = 5'h1F;

  // Keypad wiring: push-button bit index to extended-BCD code.
  function automatic logic [4:0] key_code(input logic [3:0] idx);
    logic [4:0] code;
    case (idx)
      4'd0:    code = KEY_DIGIT0 + 5'd1;
      4'd1:    code = KEY_DIGIT0 + 5'd2;
      4'd2:    code = KEY_DIGIT0 + 5'd3;
      4'd3:    code = KEY_DIV;
      4'd4:    code = KEY_DIGIT0 + 5'd4;
      4'd5:    code = KEY_DIGIT0 + 5'd5;
      4'd6:    code = KEY_DIGIT0 + 5'd6;
      4'd7:    code = KEY_MUL;
      4'd8:    code = KEY_DIGIT0 + 5'd7;
      4'd9:    code = KEY_DIGIT0 + 5'd8;
      4'd10:   code = KEY_DIGIT0 + 5'd9;
      4'd11:   code = KEY_ADD;
      4'd12:   code = KEY_SUB;
      4'd13:   code = KEY_DIGIT0;
      4'd14:   code = KEY_ANS;
      default: code = KEY_EQ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational signed arithmetic with divide-by-zero, bad-operator and
// display-range checks; returns {err, result}.
module calc_alu
  import calc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [32:0] res
);

  logic signed [63:0] wa;
  logic signed [63:0] wb;
  logic signed [63:0] wdiv;
  logic signed [63:0] wide;
  logic               err;
  logic               b_zero;

  assign wa     = {{32{a[31]}}, a};
  assign wb     = {{32{b[31]}}, b};
  assign b_zero = (b == 32'd0);
  // Substitute a harmless divisor so the divider never sees zero.
  assign wdiv   = b_zero ? 64'sd1 : wb;

  always_comb begin
    wide = '0;
    err  = 1'b0;
    case (op_e'(op))
      OpMul: wide = wa * wb;
      OpDiv: begin
        wide = wa / wdiv;
        err  = b_zero;
      end
      OpAdd: wide = wa + wb;
      OpSub: wide = wa - wb;
      OpMod: begin
        wide = wa % wdiv;
        err  = b_zero;
      end
      default: err = 1'b1;
    endcase
    if (wide > DISP_MAX || wide < DISP_MIN) err = 1'b1;
  end

  assign res = {err, wide[31:0]};

endmodule

// File: rtl/calc_engine.sv
// Calculator front-end: clock divider, one-shot keypad encoder and a
// registered signed ALU stage.
module calc_engine
  import calc_pkg::*;
#(
  parameter int SW_BIT  = 20,
  parameter int FND_BIT = 16
) (
  input  logic        clock_50m,
  input  logic        rst,
  input  logic [15:0] pb,
  input  logic        cal_enable,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  operator,
  output logic        sw_clk,
  output logic        fnd_clk,
  output logic [4:0]  eBCD,
  output logic        key_rst,
  output logic [31:0] ans
);

  logic [SW_BIT:0] cnt;
  logic            sw_tick;
  logic [15:0]     pressed;
  logic            any_key;
  logic            combo;
  logic            prev_any;
  logic [4:0]      low_code;
  logic [32:0]     alu_res;

  assign sw_clk  = cnt[SW_BIT];
  assign fnd_clk = cnt[FND_BIT];
  assign sw_tick = &cnt;

  assign pressed = ~pb;
  assign any_key = |pressed;
  assign combo   = pressed[14] & pressed[15];

  // Scan from the top down so the lowest pressed bit wins.
  always_comb begin
    low_code = KEY_NONE;
    for (int i = 15; i >= 0; i--) begin
      if (pressed[i]) low_code = key_code(4'(i));
    end
  end

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      prev_any <= 1'b0;
      eBCD     <= KEY_NONE;
      key_rst  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (sw_tick) begin
        prev_any <= any_key;
        key_rst  <= combo;
        eBCD     <= (any_key && !prev_any && !combo) ? low_code : KEY_NONE;
      end
    end
  end

  calc_alu u_alu (
    .a   (operand1),
    .b   (operand2),
    .op  (operator),
    .res (alu_res)
  );

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      ans <= '0;
    end else if (cal_enable) begin
      ans <= alu_res[32] ? ERR_CODE : alu_res[31:0];
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine with SW_BIT=3, FND_BIT=1.
module tb_calc_engine;

  localparam logic [31:0] ERR = 32'h00EE_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pb = 16'hFFFF;
  logic        cal_enable = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [2:0]  operator = '0;
  logic        sw_clk;
  logic        fnd_clk;
  logic [4:0]  eBCD;
  logic        key_rst;
  logic [31:0] ans;

  int passed = 0;
  int total  = 0;
  int cyc;

  calc_engine #(
    .SW_BIT  (3),
    .FND_BIT (1)
  ) dut (
    .clock_50m  (clk),
    .rst        (rst),
    .pb         (pb),
    .cal_enable (cal_enable),
    .operand1   (operand1),
    .operand2   (operand2),
    .operator   (operator),
    .sw_clk     (sw_clk),
    .fnd_clk    (fnd_clk),
    .eBCD       (eBCD),
    .key_rst    (key_rst),
    .ans        (ans)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release; a tick edge is every 16th.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Return at the negedge just after the next keypad tick edge.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % 16) != 0 && n < 40);
    if (n >= 40) chk("tick_timeout", 32'd1, 32'd0);
  endtask

  task automatic press(input logic [15:0] pbv, input logic [4:0] code, input string tag);
    pb = pbv;
    wait_tick();
    chk({tag, "_code"}, 32'(eBCD), 32'(code));
    repeat (15) @(negedge clk);
    chk({tag, "_hold"}, 32'(eBCD), 32'(code));
    wait_tick();
    chk({tag, "_once"}, 32'(eBCD), 32'h0);
    wait_tick();
    chk({tag, "_held"}, 32'(eBCD), 32'h0);
    pb = 16'hFFFF;
    wait_tick();
    chk({tag, "_rel"}, 32'(eBCD), 32'h0);
  endtask

  task automatic calc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] exp, input string tag);
    operand1   = a;
    operand2   = b;
    operator   = op;
    cal_enable = 1'b1;
    @(negedge clk);
    cal_enable = 1'b0;
    chk(tag, ans, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ans", ans, 32'h0);
    chk("rst_ebcd", 32'(eBCD), 32'h0);
    chk("rst_keyrst", 32'(key_rst), 32'h0);
    chk("rst_clks", 32'({sw_clk, fnd_clk}), 32'h0);
    rst = 1'b0;

    // cnt = k after k edges: fnd_clk = bit1, sw_clk = bit3
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("div_fnd", 32'(fnd_clk), 32'((k >> 1) & 1));
      chk("div_sw", 32'(sw_clk), 32'((k >> 3) & 1));
    end

    press(~16'h0001, 5'h11, "key1");
    press(~16'h0008, 5'h1B, "key_div");
    press(~16'h0080, 5'h1A, "key_mul");
    press(~16'h0800, 5'h1C, "key_add");
    press(~16'h1000, 5'h1D, "key_sub");
    press(~16'h2000, 5'h10, "key0");
    press(~16'h4000, 5'h1E, "key_ans");
    press(~16'h8000, 5'h1F, "key_eq");

    pb = ~16'hC000;
    wait_tick();
    chk("combo_rst", 32'(key_rst), 32'h1);
    chk("combo_code", 32'(eBCD), 32'h0);
    wait_tick();
    chk("combo_hold", 32'(key_rst), 32'h1);
    pb = 16'hFFFF;
    wait_tick();
    chk("combo_rel", 32'(key_rst), 32'h0);
    chk("combo_rel_code", 32'(eBCD), 32'h0);

    pb = ~16'h0005;
    wait_tick();
    chk("multi_code", 32'(eBCD), 32'h11);
    wait_tick();
    chk("multi_once", 32'(eBCD), 32'h0);
    pb = ~16'h0007;
    wait_tick();
    chk("multi_add", 32'(eBCD), 32'h0);
    pb = 16'hFFFF;
    wait_tick();

    calc(32'd10, 32'd101, 3'd3, 32'd111, "p_add");
    calc(32'd10, 32'd101, 3'd4, -32'sd91, "p_sub");
    calc(32'd10, 32'd101, 3'd1, 32'd1010, "p_mul");
    calc(32'd10, 32'd101, 3'd2, 32'd0, "p_div");
    calc(32'd10, 32'd101, 3'd5, 32'd10, "p_mod");
    calc(-32'sd10, 32'd101, 3'd3, 32'd91, "n_add");
    calc(-32'sd10, 32'd101, 3'd4, -32'sd111, "n_sub");
    calc(-32'sd10, 32'd101, 3'd1, -32'sd1010, "n_mul");
    calc(-32'sd10, 32'd101, 3'd2, 32'd0, "n_div");
    calc(-32'sd10, 32'd101, 3'd5, -32'sd10, "n_mod");
    calc(-32'sd10, -32'sd101, 3'd3, -32'sd111, "nn_add");
    calc(-32'sd10, -32'sd101, 3'd4, 32'd91, "nn_sub");
    calc(-32'sd10, -32'sd101, 3'd1, 32'd1010, "nn_mul");
    calc(-32'sd10, -32'sd101, 3'd5, -32'sd10, "nn_mod");
    calc(32'd100000, -32'sd500, 3'd3, 32'd99500, "b_add");
    calc(32'd100000, -32'sd500, 3'd4, 32'd100500, "b_sub");
    calc(32'd100000, -32'sd500, 3'd1, ERR, "b_mul");
    calc(32'd100000, -32'sd500, 3'd2, -32'sd200, "b_div");
    calc(32'd100000, -32'sd500, 3'd5, 32'd0, "b_mod");
    calc(32'd1023, 32'd0, 3'd3, 32'd1023, "z_add");
    calc(32'd1023, 32'd0, 3'd4, 32'd1023, "z_sub");
    calc(32'd1023, 32'd0, 3'd1, 32'd0, "z_mul");
    calc(32'd1023, 32'd0, 3'd2, ERR, "z_div");
    calc(32'd1023, 32'd0, 3'd5, ERR, "z_mod");
    calc(32'd1, 32'd1, 3'd0, ERR, "op0");
    calc(32'd1, 32'd1, 3'd6, ERR, "op6");
    calc(32'd1, 32'd1, 3'd7, ERR, "op7");
    calc(-32'sd7, 32'd2, 3'd2, -32'sd3, "trunc_div");
    calc(-32'sd7, 32'd2, 3'd5, -32'sd1, "sign_mod");
    calc(32'd7, -32'sd2, 3'd5, 32'd1, "pos_mod");
    calc(32'd999998, 32'd1, 3'd3, 32'd999999, "max_ok");
    calc(32'd999999, 32'd1, 3'd3, ERR, "max_err");
    calc(32'd0, 32'd99999, 3'd4, -32'sd99999, "min_ok");
    calc(32'd0, 32'd100000, 3'd4, ERR, "min_err");
    calc(32'h8000_0000, 32'hFFFF_FFFF, 3'd2, ERR, "ovf_div");
    calc(32'd99999, 32'd10, 3'd1, 32'd999990, "mul_ok");

    // Back-to-back strobes
    operand1   = 32'd5;
    operand2   = 32'd6;
    operator   = 3'd1;
    cal_enable = 1'b1;
    @(negedge clk);
    chk("b2b_first", ans, 32'd30);
    operand1 = 32'd40;
    operand2 = 32'd2;
    operator = 3'd4;
    @(negedge clk);
    chk("b2b_second", ans, 32'd38);
    @(negedge clk);
    chk("idempotent", ans, 32'd38);
    cal_enable = 1'b0;
    operand1   = 32'd1000;
    operator   = 3'd3;
    repeat (3) @(negedge clk);
    chk("hold", ans, 32'd38);

    #2 rst = 1'b1;
    #1 chk("rst_mid_ans", ans, 32'h0);
    chk("rst_mid_clks", 32'({sw_clk, fnd_clk}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
